egress_arbiter: RTL and testbench
=================================

EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
Parameters:
- REQ-001 The block SHALL have parameter WORD_SIZE, default 12, giving the data word width.
- REQ-002 The block SHALL have parameter INDEX, default 2, giving the channel-select width; the channel count is fixed at 4.
- REQ-003 The block SHALL have parameter CNT_W, default 5, giving the per-channel counter width.

Ports:
- REQ-004 The port list SHALL be:
  - clk  in  1  single clock; all state updates on its rising edge.
  - reset  in  1  asynchronous, active-high reset.
  - enable  in  1  arbitration enable.
  - fifo_empty  in  4  empty flag of upstream FIFO k (bit k = S_k).
  - data_in_S0..data_in_S3  in  WORD_SIZE each  upstream FIFO read data, valid the cycle after the FIFO is popped.
  - sink_pause  in  1  downstream backpressure.
  - req  in  1  counter read request.
  - idx  in  INDEX  counter select.
  - pop  out  4  one-hot pop strobe to the upstream FIFOs.
  - data_out  out  WORD_SIZE  serialized word.
  - valid_out  out  1  data_out qualifier.
  - src_out  out  INDEX  source channel of data_out.
  - cuenta  out  CNT_W  counter readout.
  - cuenta_valid  out  1  cuenta qualifier.
  - state  out  2  FSM state.

Function
- REQ-005 The FSM SHALL have states RESET=0, IDLE=1 and ACTIVE=2; encoding 3 SHALL be unreachable and SHALL recover to RESET.
- REQ-006 The FSM SHALL move RESET->IDLE unconditionally on the first clock after reset deasserts.
- REQ-007 The FSM SHALL move IDLE->ACTIVE when enable=1 and ACTIVE->IDLE when enable=0.
- REQ-008 pop SHALL be asserted only in ACTIVE with sink_pause=0, SHALL have at most one bit set per cycle, and SHALL never set bit k while fifo_empty[k]=1.
- REQ-009 Grants SHALL be round-robin: the search starts at the channel after the last granted one, wrapping 3->0; the pointer is 0 after reset.
- REQ-010 A channel granted in cycle N SHALL be ineligible in cycle N+1, guarding against a stale empty flag; back-to-back grants to different channels SHALL be allowed.
- REQ-011 If pop[k] is asserted in cycle N, then in cycle N+1 the block SHALL set data_out=data_in_Sk, src_out=k and valid_out=1, giving a latency of exactly 1 cycle.
- REQ-012 valid_out SHALL be 0 in every cycle not preceded by a pop; data_out and src_out SHALL hold their last values while valid_out=0.
- REQ-013 A pop issued in cycle N SHALL still deliver its word in N+1 when sink_pause or enable falls in N+1, so no word is lost.
- REQ-014 The block SHALL keep four CNT_W-bit counters, one per channel, each incremented when a word from that channel is delivered (valid_out=1 with src_out=k).
- REQ-015 Each counter SHALL saturate at 2^CNT_W-1 (31 at the default width) rather than wrap.
- REQ-016 When req=1 in cycle N, the block SHALL drive cuenta=counter[idx] as it stood in cycle N, with cuenta_valid=1, in cycle N+1; otherwise cuenta_valid=0 and cuenta holds its last value.
- REQ-017 A counter read in the same cycle as an increment of that counter SHALL return the pre-increment value; the increment SHALL NOT be lost.

Reset
- REQ-018 While reset=1, asynchronously: state=RESET, pop=0, valid_out=0, data_out=0, src_out=0, cuenta=0, cuenta_valid=0, all counters=0, RR pointer=0.
- REQ-019 Reset asserted mid-operation SHALL discard any in-flight word (no valid_out afterwards) and SHALL clear all counters.

Verification
- REQ-020 Reset, then enable=1 with all fifo_empty=1 -> state 0->1->2; pop stays 0 and valid_out stays 0.
- REQ-021 fifo_empty=4'b0000, with 0xA01/0xB02/0xC03/0xD04 presented the cycle after each pop -> pop sequence 0001,0010,0100,1000,0001; data_out sequence A01,B02,C03,D04 with src_out 0,1,2,3; each valid_out 1 cycle after its pop.
- REQ-022 Only S2 non-empty for 6 cycles -> pop[2] at most every other cycle; counter[2] = 3; req=1, idx=2 -> cuenta=3 and cuenta_valid=1 next cycle.
- REQ-023 sink_pause=1 raised the cycle after a pop -> that word is still delivered; no further pop until sink_pause=0.
- REQ-024 40 deliveries from S1 -> counter[1] reads 31; a read coincident with an increment returns the old value.
- REQ-025 Reset asserted mid-stream with a pop outstanding -> no valid_out on the next edge; all outputs at their reset values; counter[*] reads 0.

Source files
------------

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : egress_arbiter
// Brief    : 4-channel round-robin FIFO drain with 1-cycle delivery and
//            saturating per-channel delivery counters.
// Revision : 1.0 - initial release
// ============================================================================
module egress_arbiter #(
    parameter int WORD_SIZE = 12,
    parameter int INDEX     = 2,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           fifo_empty,
    input  logic [WORD_SIZE-1:0] data_in_S0,
    input  logic [WORD_SIZE-1:0] data_in_S1,
    input  logic [WORD_SIZE-1:0] data_in_S2,
    input  logic [WORD_SIZE-1:0] data_in_S3,
    input  logic                 sink_pause,
    input  logic                 req,
    input  logic [INDEX-1:0]     idx,
    output logic [3:0]           pop,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [INDEX-1:0]     src_out,
    output logic [CNT_W-1:0]     cuenta,
    output logic                 cuenta_valid,
    output logic [1:0]           state
);

    localparam logic [1:0] c_ST_RESET  = 2'd0;
    localparam logic [1:0] c_ST_IDLE   = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [3:0]           r_pop_d;
    logic [1:0]           r_ptr;
    logic [3:0]           w_elig;
    logic [3:0]           w_pop;
    logic [1:0]           w_gnt_ch;
    logic [1:0]           w_ch;
    logic                 w_found;
    logic [1:0]           w_dlv_ch;
    logic [WORD_SIZE-1:0] w_dlv_word;
    logic [WORD_SIZE-1:0] r_data_hold;
    logic [INDEX-1:0]     r_src_hold;
    logic [CNT_W-1:0]     w_cnt [4];
    logic [CNT_W-1:0]     r_cuenta;
    logic                 r_cuenta_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_RESET;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = c_ST_RESET;
        case (r_state)
            c_ST_RESET:  w_state_nxt = c_ST_IDLE;
            c_ST_IDLE:   w_state_nxt = enable ? c_ST_ACTIVE : c_ST_IDLE;
            c_ST_ACTIVE: w_state_nxt = enable ? c_ST_ACTIVE : c_ST_IDLE;
            default:     w_state_nxt = c_ST_RESET;
        endcase
    end

    // Last cycle's grant is masked: its empty flag may not yet reflect the pop.
    always_comb begin
        w_elig   = ~fifo_empty & ~r_pop_d &
                   {4{(r_state == c_ST_ACTIVE) && !sink_pause}};
        w_pop    = '0;
        w_gnt_ch = r_ptr;
        w_found  = 1'b0;
        w_ch     = '0;
        for (int o = 0; o < 4; o++) begin
            w_ch = r_ptr + 2'(o);
            if (!w_found && w_elig[w_ch]) begin
                w_pop[w_ch] = 1'b1;
                w_gnt_ch    = w_ch;
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop_d <= '0;
            r_ptr   <= '0;
        end else begin
            r_pop_d <= w_pop;
            if (w_found) r_ptr <= w_gnt_ch + 2'd1;
        end
    end

    always_comb begin
        w_dlv_ch = 2'd0;
        case (r_pop_d)
            4'b0010: w_dlv_ch = 2'd1;
            4'b0100: w_dlv_ch = 2'd2;
            4'b1000: w_dlv_ch = 2'd3;
            default: w_dlv_ch = 2'd0;
        endcase
    end

    always_comb begin
        w_dlv_word = data_in_S0;
        case (w_dlv_ch)
            2'd1:    w_dlv_word = data_in_S1;
            2'd2:    w_dlv_word = data_in_S2;
            2'd3:    w_dlv_word = data_in_S3;
            default: w_dlv_word = data_in_S0;
        endcase
    end

    // Upstream read data is only valid the cycle after the pop, so the word
    // is passed through combinationally and captured for the hold value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_hold <= '0;
            r_src_hold  <= '0;
        end else if (valid_out) begin
            r_data_hold <= w_dlv_word;
            r_src_hold  <= INDEX'(w_dlv_ch);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        logic [CNT_W-1:0] r_val;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_val <= '0;
            else if (valid_out && (w_dlv_ch == 2'(k)) && (r_val != '1))
                r_val <= r_val + CNT_W'(1);
        end
        assign w_cnt[k] = r_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cuenta       <= '0;
            r_cuenta_valid <= 1'b0;
        end else begin
            r_cuenta_valid <= req;
            if (req) r_cuenta <= w_cnt[idx[1:0]];
        end
    end

    assign pop          = w_pop;
    assign valid_out    = |r_pop_d;
    assign data_out     = valid_out ? w_dlv_word : r_data_hold;
    assign src_out      = valid_out ? INDEX'(w_dlv_ch) : r_src_hold;
    assign cuenta       = r_cuenta;
    assign cuenta_valid = r_cuenta_valid;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_egress_arbiter
// Brief    : Directed scoreboard bench for egress_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egress_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  fifo_empty;
    logic [11:0] d0, d1, d2, d3;
    logic        sink_pause;
    logic        req;
    logic [1:0]  idx;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic [1:0]  src_out;
    logic [4:0]  cuenta;
    logic        cuenta_valid;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [13:0] q_word [$];
    int          q_wdue [$];
    logic [4:0]  q_cnt  [$];
    int          q_cdue [$];

    egress_arbiter #(.WORD_SIZE(12), .INDEX(2), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .data_in_S0(d0), .data_in_S1(d1), .data_in_S2(d2), .data_in_S3(d3),
        .sink_pause(sink_pause), .req(req), .idx(idx), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
        .cuenta(cuenta), .cuenta_valid(cuenta_valid), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        logic [13:0] ew;
        logic [4:0]  ec;
        int          due;
        if (valid_out) begin
            n_vec++;
            if (q_word.size() == 0) begin
                n_err++;
                $display("FAIL word: unexpected valid_out src=%0d data=%h, required none", src_out, data_out);
            end else begin
                ew  = q_word.pop_front();
                due = q_wdue.pop_front();
                if ({src_out, data_out} !== ew || due != cyc) begin
                    n_err++;
                    $display("FAIL word: got src=%0d data=%h cyc=%0d, required src=%0d data=%h cyc=%0d",
                             src_out, data_out, cyc, ew[13:12], ew[11:0], due);
                end
            end
        end else if (q_wdue.size() != 0 && q_wdue[0] <= cyc) begin
            n_vec++;
            n_err++;
            ew = q_word.pop_front();
            void'(q_wdue.pop_front());
            $display("FAIL word: got no valid_out, required src=%0d data=%h", ew[13:12], ew[11:0]);
        end
        if (cuenta_valid) begin
            n_vec++;
            if (q_cnt.size() == 0) begin
                n_err++;
                $display("FAIL cuenta: unexpected cuenta_valid value=%0d, required none", cuenta);
            end else begin
                ec  = q_cnt.pop_front();
                due = q_cdue.pop_front();
                if (cuenta !== ec || due != cyc) begin
                    n_err++;
                    $display("FAIL cuenta: got %0d cyc=%0d, required %0d cyc=%0d", cuenta, cyc, ec, due);
                end
            end
        end else if (q_cdue.size() != 0 && q_cdue[0] <= cyc) begin
            n_vec++;
            n_err++;
            ec = q_cnt.pop_front();
            void'(q_cdue.pop_front());
            $display("FAIL cuenta: got no cuenta_valid, required %0d", ec);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [3:0] onehot);
        logic [1:0]  ch;
        logic [11:0] w;
        case (onehot)
            4'b0010: begin ch = 2'd1; w = 12'hB02; end
            4'b0100: begin ch = 2'd2; w = 12'hC03; end
            4'b1000: begin ch = 2'd3; w = 12'hD04; end
            default: begin ch = 2'd0; w = 12'hA01; end
        endcase
        q_word.push_back({ch, w});
        q_wdue.push_back(cyc + 1);
    endtask

    task automatic expect_pop(input logic [3:0] e, input bit push);
        #1;
        chk("pop", {28'd0, pop}, {28'd0, e});
        if (push && e != 4'd0) push_word(e);
    endtask

    task automatic read_cnt(input logic [1:0] ch, input logic [4:0] e);
        req = 1'b1;
        idx = ch;
        q_cnt.push_back(e);
        q_cdue.push_back(cyc + 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"},     {30'd0, state}, 32'd0);
        chk({tag, "_pop"},       {28'd0, pop}, 32'd0);
        chk({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
        chk({tag, "_data_out"},  {20'd0, data_out}, 32'd0);
        chk({tag, "_src_out"},   {30'd0, src_out}, 32'd0);
        chk({tag, "_cuenta"},    {27'd0, cuenta}, 32'd0);
        chk({tag, "_cuenta_v"},  {31'd0, cuenta_valid}, 32'd0);
    endtask

    localparam logic [3:0] c_P021 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] c_P022 [6] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};

    initial begin
        reset = 1'b1; enable = 1'b0; fifo_empty = 4'hF; sink_pause = 1'b0;
        req = 1'b0; idx = 2'd0;
        d0 = 12'hA01; d1 = 12'hB02; d2 = 12'hC03; d3 = 12'hD04;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");

        // Bring-up with every FIFO empty
        next_cycle(); reset = 1'b0; enable = 1'b1; #1 chk("st_first", {30'd0, state}, 32'd0);
        next_cycle(); #1 chk("st_idle", {30'd0, state}, 32'd1);
        next_cycle(); #1 chk("st_active", {30'd0, state}, 32'd2);
        repeat (2) begin next_cycle(); expect_pop(4'b0000, 1'b1); end

        // All four channels ready: plain rotation
        for (int i = 0; i < 5; i++) begin
            next_cycle(); fifo_empty = 4'h0; expect_pop(c_P021[i], 1'b1);
        end
        next_cycle(); fifo_empty = 4'hF; expect_pop(4'b0000, 1'b1);
        next_cycle(); read_cnt(2'd0, 5'd2);
        next_cycle(); read_cnt(2'd1, 5'd1);
        next_cycle(); read_cnt(2'd3, 5'd1);
        next_cycle(); req = 1'b0;
        next_cycle(); chk("q_after_rr", q_word.size() + q_cnt.size(), 32'd0);

        // Reset lands while a popped word is still in flight
        fifo_empty = 4'h0; expect_pop(4'b0010, 1'b0);
        #1 reset = 1'b1;
        @(negedge clk); chk_reset_outputs("midrst");
        @(negedge clk); chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        next_cycle(); reset = 1'b0; fifo_empty = 4'hF; read_cnt(2'd0, 5'd0);
        next_cycle(); read_cnt(2'd1, 5'd0);
        next_cycle(); req = 1'b0; #1 chk("st_reactive", {30'd0, state}, 32'd2);

        // Single busy channel: stale-flag guard spaces the grants
        for (int i = 0; i < 6; i++) begin
            next_cycle(); fifo_empty = 4'b1011; expect_pop(c_P022[i], 1'b1);
        end
        next_cycle(); fifo_empty = 4'hF; read_cnt(2'd2, 5'd3); expect_pop(4'b0000, 1'b1);
        next_cycle(); req = 1'b0;

        // Backpressure raised right after a pop
        next_cycle(); fifo_empty = 4'b1101; expect_pop(4'b0010, 1'b1);
        next_cycle(); sink_pause = 1'b1; expect_pop(4'b0000, 1'b1);
        repeat (2) begin next_cycle(); expect_pop(4'b0000, 1'b1); end
        next_cycle(); sink_pause = 1'b0; expect_pop(4'b0010, 1'b1);
        next_cycle(); fifo_empty = 4'hF; expect_pop(4'b0000, 1'b1);

        // 40 deliveries from S1 with reads coinciding with increments
        for (int i = 0; i < 80; i++) begin
            next_cycle();
            fifo_empty = 4'b1101;
            req = 1'b0;
            if (i == 3) read_cnt(2'd1, 5'd3);
            if (i == 5) read_cnt(2'd1, 5'd4);
            expect_pop((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
        end
        next_cycle(); fifo_empty = 4'hF; read_cnt(2'd1, 5'd31); expect_pop(4'b0000, 1'b1);
        next_cycle(); req = 1'b0;
        repeat (2) next_cycle();
        chk("q_final", q_word.size() + q_cnt.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
